// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester ALU arbiter with operand/response registers and flags
module alu_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req1_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_b,
  input  logic [4:0]  req0_op,
  input  logic [4:0]  req1_op,
  input  logic        req0_s,
  input  logic        req1_s,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_op,
  output logic        alu_carry,
  input  logic [31:0] alu_result,
  input  logic [3:0]  alu_flags,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_result,
  output logic [3:0]  resp_flags,
  output logic        resp_err,
  output logic [3:0]  flags
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q;
  logic        last_grant_q;
  logic [31:0] opa_q;
  logic [31:0] opb_q;
  logic [4:0]  op_q;
  logic        s_q;
  logic        id_q;
  logic [31:0] res_q;
  logic [3:0]  res_flags_q;
  logic        err_q;
  logic [3:0]  flags_q;

  logic        grant_valid_d;
  logic        grant_id_d;
  logic        op_illegal;

  // Opcodes 0..15 write flags: test/compare (8..11) always, others only on s.
  // Opcodes 16 and above never touch the flags register.
  function automatic logic flags_write(input logic [4:0] op, input logic s);
    if (op[4]) begin
      return 1'b0;
    end else if (op[3:2] == 2'b10) begin
      return 1'b1;
    end else begin
      return s;
    end
  endfunction

  assign op_illegal = (op_q > 5'd20);

  // Arbitration: on a tie the requester that did not win last time is chosen.
  always_comb begin
    grant_valid_d = 1'b0;
    grant_id_d    = 1'b0;
    if (state_q == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant_valid_d = 1'b1;
        grant_id_d    = ~last_grant_q;
      end else if (req0_valid) begin
        grant_valid_d = 1'b1;
        grant_id_d    = 1'b0;
      end else if (req1_valid) begin
        grant_valid_d = 1'b1;
        grant_id_d    = 1'b1;
      end
    end
  end

  // Control FSM plus operand, response and flags registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      opa_q        <= '0;
      opb_q        <= '0;
      op_q         <= '0;
      s_q          <= 1'b0;
      id_q         <= 1'b0;
      res_q        <= '0;
      res_flags_q  <= '0;
      err_q        <= 1'b0;
      flags_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_valid_d) begin
            last_grant_q <= grant_id_d;
            id_q         <= grant_id_d;
            opa_q        <= grant_id_d ? req1_a  : req0_a;
            opb_q        <= grant_id_d ? req1_b  : req0_b;
            op_q         <= grant_id_d ? req1_op : req0_op;
            s_q          <= grant_id_d ? req1_s  : req0_s;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          if (op_illegal) begin
            res_q       <= '0;
            res_flags_q <= '0;
            err_q       <= 1'b1;
          end else begin
            res_q       <= alu_result;
            res_flags_q <= alu_flags;
            err_q       <= 1'b0;
            if (flags_write(op_q, s_q)) begin
              flags_q <= alu_flags;
            end
          end
          state_q <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Grant pulses are suppressed while reset is held.
  assign req0_ready  = rst_n && grant_valid_d && !grant_id_d;
  assign req1_ready  = rst_n && grant_valid_d &&  grant_id_d;

  assign alu_a       = opa_q;
  assign alu_b       = opb_q;
  assign alu_op      = op_q;
  assign alu_carry   = flags_q[1];

  assign resp_valid  = (state_q == RESP);
  assign resp_id     = id_q;
  assign resp_result = res_q;
  assign resp_flags  = res_flags_q;
  assign resp_err    = err_q;
  assign flags       = flags_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have ports, one per line:
  clk  in  1  sole clock, rising edge
  rst_n  in  1  asynchronous active-low reset
  req0_valid, req1_valid  in  1  requester n has an operation pending
  req0_ready, req1_ready  out  1  grant pulse; operation accepted this cycle
  req0_a/req1_a, req0_b/req1_b  in  32  operands
  req0_op, req1_op  in  5  ALU opcode
  req0_s, req1_s  in  1  set-flags request
  alu_a, alu_b  out  32  operands to ALU
  alu_op  out  5  opcode to ALU
  alu_carry  out  1  carry-in to ALU
  alu_result  in  32  ALU result
  alu_flags  in  4  ALU {N,Z,C,V}
  resp_valid  out  1  response available
  resp_ready  in  1  consumer accepts response
  resp_id  out  1  requester index of response
  resp_result  out  32  captured result
  resp_flags  out  4  captured {N,Z,C,V}
  resp_err  out  1  illegal opcode
  flags  out  4  architectural {N,Z,C,V} register
REQ-002 SHALL use one clock (clk); reset rst_n is asynchronous and active-low.

Function
REQ-003 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-004 IDLE: any reqN_valid -> grant one requester, assert its reqN_ready for exactly that cycle, latch a/b/op/s/id into operand registers, next EXEC; no valid -> stay IDLE.
REQ-005 reqN_ready SHALL be asserted only in IDLE, for at most one requester per cycle.
REQ-006 Both valid in IDLE: grant requester != last_grant; last_grant updates on every grant.
REQ-007 Single valid: granted regardless of last_grant.
REQ-008 alu_a/alu_b/alu_op SHALL be driven from operand registers (stable through EXEC); alu_carry = flags[C] (bit 1).
REQ-009 EXEC: capture alu_result, alu_flags into resp registers at end of cycle; next RESP.
REQ-010 Flags register update at end of EXEC: op 01000-01011 (test/compare) always; ops 00000-00111, 01100-01111 only when latched s=1; ops 10000-10100 never.
REQ-011 Opcode > 10100: resp_err=1, resp_result=0, resp_flags=0, flags unchanged.
REQ-012 RESP: resp_valid=1, resp_* held stable until resp_ready=1; handshake cycle -> IDLE.
REQ-013 Latency: grant at cycle T -> resp_valid at T+2; minimum issue interval 3 cycles (resp_ready held high).
REQ-014 Flags written by an operation SHALL be visible on alu_carry for the next granted operation.
REQ-015 reqN_valid deassertion without grant SHALL be legal; nothing latched.
REQ-016 resp_valid SHALL be 0 in IDLE and EXEC.

Reset
REQ-017 rst_n low, any state: state=IDLE, last_grant=1 (so requester 0 wins first tie), flags=0000, operand and resp registers=0, resp_valid=0, reqN_ready=0, resp_err=0.
REQ-018 Reset during EXEC or RESP SHALL discard the in-flight operation with no response and no flags write.
REQ-019 First grant SHALL occur no earlier than the first rising edge after rst_n deasserts.

Verification
REQ-020 req0 op=00100 a=0x7FFFFFFF b=1 s=1 -> resp at T+2: result 0x80000000, resp_flags N=1 Z=0 C=0 V=1, flags=1001.
REQ-021 req0 and req1 valid every cycle from reset, resp_ready=1 -> grants 0,1,0,1 spaced 3 cycles; resp_id alternates.
REQ-022 Op 01010 a=5 b=5 s=0 -> flags Z=1 updated; then op 00100 s=0 -> flags unchanged.
REQ-023 Op 00101 after flags C=1, a=1 b=1 -> alu_carry=1 during EXEC, result 3.
REQ-024 resp_ready held low 5 cycles in RESP -> resp_* stable, no new grant; release -> IDLE next cycle.
REQ-025 Op 11111 -> resp_err=1, result 0, flags unchanged; rst_n pulse in EXEC -> no resp_valid, flags=0000.
